grid_sram_responder: RTL

- Owns the single external SRAM port that holds the 40x30 entity grid, one 16-bit word per cell.
- Answers cell-read requests from the pixel drawer with the stored entity/colour word.
- Accepts cell-write requests from game logic.
- Runs a background clear of the whole grid on command, so game logic no longer drives the SRAM pins directly.

---
 rtl/grid_sram_if.sv | 33 +++
 rtl/grid_sram_responder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/grid_sram_if.sv
// Request/response bundle between grid clients and the grid SRAM responder.
// Drawer reads, game-logic writes and the clear command share one port.
interface grid_sram_if;
    logic        rd_req;
    logic [5:0]  rd_x;
    logic [5:0]  rd_y;
    logic        rd_ack;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        wr_req;
    logic [5:0]  wr_x;
    logic [5:0]  wr_y;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        clr_start;
    logic        clr_busy;

    modport master (
        output rd_req, rd_x, rd_y,
        output wr_req, wr_x, wr_y, wr_data,
        output clr_start,
        input  rd_ack, rd_valid, rd_data,
        input  wr_ack, clr_busy
    );

    modport slave (
        input  rd_req, rd_x, rd_y,
        input  wr_req, wr_x, wr_y, wr_data,
        input  clr_start,
        output rd_ack, rd_valid, rd_data,
        output wr_ack, clr_busy
    );
endinterface

// File: rtl/grid_sram_responder.sv
// Sole owner of the external SRAM holding the entity grid: serves reads,
// writes and a background full-grid clear through one sequencer.
module grid_sram_responder #(
    parameter int unsigned GRID_W      = 40,
    parameter int unsigned GRID_H      = 30,
    parameter logic [17:0] BASE_ADDR   = 18'd0,
    parameter logic [15:0] CLEAR_VALUE = 16'h0000,
    parameter logic [15:0] OOB_VALUE   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    grid_sram_if.slave  bus,
    inout  wire  [15:0] sram_dq,
    output logic [17:0] sram_addr,
    output logic        sram_we_n
);

    localparam int unsigned CELLS = GRID_W * GRID_H;
    localparam int unsigned CNT_W = $clog2(CELLS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CELLS - 1);
    localparam logic [6:0] W7 = 7'(GRID_W);
    localparam logic [6:0] H7 = 7'(GRID_H);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_SAMPLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] clr_cnt;
    logic             clr_busy_q;
    logic             step_clr;
    logic             step_last;
    logic             rd_oob;
    logic             rd_valid_q;
    logic [15:0]      rd_data_q;
    logic             dq_oe;
    logic [15:0]      dq_out;

    logic             rd_in;
    logic             wr_in;
    logic             rd_go;
    logic             wr_go;
    logic             clr_go;
    logic [17:0]      rd_a;
    logic [17:0]      wr_a;

    // y*40 is built from two shifts so no multiplier is needed.
    function automatic logic [17:0] cell_addr(
        input logic [5:0] x,
        input logic [5:0] y
    );
        logic [17:0] yy;
        logic [17:0] row;
        yy  = {12'd0, y};
        row = (GRID_W == 40) ? (yy << 5) + (yy << 3)
                             : yy * 18'(GRID_W);
        return BASE_ADDR + row + {12'd0, x};
    endfunction

    assign rd_in = ({1'b0, bus.rd_x} < W7) && ({1'b0, bus.rd_y} < H7);
    assign wr_in = ({1'b0, bus.wr_x} < W7) && ({1'b0, bus.wr_y} < H7);
    assign rd_a  = cell_addr(bus.rd_x, bus.rd_y);
    assign wr_a  = cell_addr(bus.wr_x, bus.wr_y);

    // Acks are decoded from the registered state so a request is
    // accepted in the same cycle the sequencer is free.
    assign rd_go  = !rst && (state == IDLE) && bus.rd_req;
    assign wr_go  = !rst && (state == IDLE) && bus.wr_req
                    && !bus.rd_req && !clr_busy_q;
    assign clr_go = (state == IDLE) && !bus.rd_req && clr_busy_q;

    assign bus.rd_ack   = rd_go;
    assign bus.wr_ack   = wr_go;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.clr_busy = clr_busy_q;

    assign sram_dq = dq_oe ? dq_out : 16'hzzzz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clr_busy_q <= 1'b0;
            step_clr   <= 1'b0;
            step_last  <= 1'b0;
            rd_oob     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            dq_oe      <= 1'b0;
            dq_out     <= '0;
            sram_addr  <= BASE_ADDR;
            sram_we_n  <= 1'b1;
        end else begin
            rd_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rd_go) begin
                        rd_oob <= !rd_in;
                        if (rd_in) sram_addr <= rd_a;
                        state <= RD_ADDR;
                    end else if (wr_go) begin
                        if (wr_in) begin
                            sram_addr <= wr_a;
                            dq_out    <= bus.wr_data;
                            dq_oe     <= 1'b1;
                            step_clr  <= 1'b0;
                            state     <= WR_SETUP;
                        end
                    end else if (clr_go) begin
                        sram_addr <= BASE_ADDR + 18'(clr_cnt);
                        dq_out    <= CLEAR_VALUE;
                        dq_oe     <= 1'b1;
                        step_clr  <= 1'b1;
                        step_last <= (clr_cnt == LAST);
                        clr_cnt   <= clr_cnt + CNT_W'(1);
                        state     <= WR_SETUP;
                    end
                end
                RD_ADDR: state <= RD_SAMPLE;
                RD_SAMPLE: begin
                    rd_data_q  <= rd_oob ? OOB_VALUE : sram_dq;
                    rd_valid_q <= 1'b1;
                    state      <= IDLE;
                end
                WR_SETUP: begin
                    sram_we_n <= 1'b0;
                    state     <= WR_PULSE;
                end
                WR_PULSE: begin
                    sram_we_n <= 1'b1;
                    state     <= WR_HOLD;
                end
                WR_HOLD: begin
                    dq_oe <= 1'b0;
                    state <= IDLE;
                    if (step_clr && step_last) clr_busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            // A new clear always wins, even over the final step's busy drop.
            if (bus.clr_start) begin
                clr_busy_q <= 1'b1;
                clr_cnt    <= '0;
            end
        end
    end

endmodule
